// File: rtl/pwm_timebase.sv
// Parametrised PWM timebase: prescaled up, down or center-aligned counter with
// shadow-buffered period/prescale, one-shot stop and single-cycle event pulses.
module pwm_timebase #(
    parameter int WIDTH     = 16,
    parameter int PSC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 count_reset,
    input  logic [1:0]           mode,
    input  logic                 one_shot,
    input  logic [WIDTH-1:0]     period,
    input  logic [PSC_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]     count_val,
    output logic                 dir,
    output logic                 tick,
    output logic                 ovf,
    output logic                 unf,
    output logic                 running
);

    typedef enum logic [1:0] {
        CNT_UP,
        CNT_DOWN,
        CNT_CENTER
    } count_mode_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_t;

    count_mode_t          cur_mode;

    logic [WIDTH-1:0]     count_q,       count_d;
    logic [PSC_WIDTH-1:0] psc_q,         psc_d;
    count_dir_t           int_dir_q,     int_dir_d;
    logic                 done_q,        done_d;
    logic [WIDTH-1:0]     period_sh,     period_sh_d;
    logic [PSC_WIDTH-1:0] prescale_sh,   prescale_sh_d;
    logic                 tick_q,        tick_d;
    logic                 ovf_q,         ovf_d;
    logic                 unf_q,         unf_d;
    logic                 dir_q,         dir_d;
    logic                 running_q,     running_d;
    logic                 step;
    logic                 update;

    always_comb begin
        cur_mode = CNT_UP;
        case (mode)
            2'b01:   cur_mode = CNT_DOWN;
            2'b10:   cur_mode = CNT_CENTER;
            default: cur_mode = CNT_UP;
        endcase
    end

    // Next-state logic; rst is applied in the register process.
    always_comb begin
        count_d       = count_q;
        psc_d         = psc_q;
        int_dir_d     = int_dir_q;
        done_d        = done_q;
        period_sh_d   = period_sh;
        prescale_sh_d = prescale_sh;
        tick_d        = 1'b0;
        ovf_d         = 1'b0;
        unf_d         = 1'b0;
        step          = 1'b0;
        update        = 1'b0;

        if (count_reset) begin
            count_d       = '0;
            psc_d         = '0;
            int_dir_d     = DIR_UP;
            done_d        = 1'b0;
            period_sh_d   = period;
            prescale_sh_d = prescale;
        end else if (!en) begin
            period_sh_d   = period;
            prescale_sh_d = prescale;
            done_d        = 1'b0;
        end else if (!done_q) begin
            // >= keeps the prescaler bounded if its shadow shrank while disabled
            if (psc_q >= prescale_sh) begin
                psc_d = '0;
                step  = 1'b1;
            end else begin
                psc_d = psc_q + PSC_WIDTH'(1);
            end
        end

        if (step) begin
            tick_d = 1'b1;
            case (cur_mode)
                CNT_DOWN: begin
                    if (count_q == '0) begin
                        count_d = period;
                        unf_d   = 1'b1;
                        update  = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                CNT_CENTER: begin
                    if (int_dir_q == DIR_UP) begin
                        if (count_q >= period_sh) begin
                            int_dir_d = DIR_DOWN;
                            count_d   = (period_sh == '0) ? '0 : period_sh - WIDTH'(1);
                            ovf_d     = 1'b1;
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end else begin
                        if (count_q == '0) begin
                            int_dir_d = DIR_UP;
                            count_d   = (period_sh == '0) ? '0 : WIDTH'(1);
                            unf_d     = 1'b1;
                            update    = 1'b1;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    if (count_q >= period_sh) begin
                        count_d = '0;
                        ovf_d   = 1'b1;
                        update  = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
            endcase

            if (update) begin
                period_sh_d   = period;
                prescale_sh_d = prescale;
                if (one_shot) begin
                    done_d = 1'b1;
                end
            end
        end

        case (cur_mode)
            CNT_DOWN:   dir_d = 1'b0;
            CNT_CENTER: dir_d = (int_dir_d == DIR_UP);
            default:    dir_d = 1'b1;
        endcase

        running_d = en & ~done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            psc_q       <= '0;
            int_dir_q   <= DIR_UP;
            done_q      <= 1'b0;
            period_sh   <= '0;
            prescale_sh <= '0;
            tick_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            dir_q       <= 1'b1;
            running_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            psc_q       <= psc_d;
            int_dir_q   <= int_dir_d;
            done_q      <= done_d;
            period_sh   <= period_sh_d;
            prescale_sh <= prescale_sh_d;
            tick_q      <= tick_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            dir_q       <= dir_d;
            running_q   <= running_d;
        end
    end

    assign count_val = count_q;
    assign dir       = dir_q;
    assign tick      = tick_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign running   = running_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Testbench for pwm_timebase: directed scenarios plus randomized traffic checked
// against a cycle-level reference model, and a WIDTH=8/PSC_WIDTH=4 long-wrap run.
module tb_pwm_timebase;

    localparam int W    = 16;
    localparam int PW   = 8;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, count_reset, one_shot;
    logic [1:0]    mode;
    logic [W-1:0]  period;
    logic [PW-1:0] prescale;
    logic [W-1:0]  count_val;
    logic          dir, tick, ovf, unf, running;

    logic          w_rst, w_en, w_count_reset, w_one_shot;
    logic [1:0]    w_mode;
    logic [7:0]    w_period;
    logic [3:0]    w_prescale;
    logic [7:0]    w_count_val;
    logic          w_dir, w_tick, w_ovf, w_unf, w_running;

    int checks   = 0;
    int failures = 0;

    int m_count, m_psc, m_up, m_done, m_per_sh, m_psc_sh;
    int m_tick, m_ovf, m_unf, m_dir, m_run;

    pwm_timebase #(.WIDTH(W), .PSC_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .en(en), .count_reset(count_reset), .mode(mode),
        .one_shot(one_shot), .period(period), .prescale(prescale),
        .count_val(count_val), .dir(dir), .tick(tick), .ovf(ovf), .unf(unf),
        .running(running)
    );

    pwm_timebase #(.WIDTH(8), .PSC_WIDTH(4)) dut_wide (
        .clk(clk), .rst(w_rst), .en(w_en), .count_reset(w_count_reset), .mode(w_mode),
        .one_shot(w_one_shot), .period(w_period), .prescale(w_prescale),
        .count_val(w_count_val), .dir(w_dir), .tick(w_tick), .ovf(w_ovf), .unf(w_unf),
        .running(w_running)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one clock edge of the timebase, from the behavioural rules.
    task automatic modelUpdate(input bit r, input bit e, input bit cr, input bit [1:0] m,
                               input bit os, input int p, input int ps);
        bit stepNow = 0;
        bit updNow  = 0;
        m_tick = 0; m_ovf = 0; m_unf = 0;
        if (r) begin
            m_count = 0; m_psc = 0; m_up = 1; m_done = 0; m_per_sh = 0; m_psc_sh = 0;
            m_dir = 1; m_run = 0;
            return;
        end
        if (cr) begin
            m_count = 0; m_psc = 0; m_up = 1; m_done = 0; m_per_sh = p; m_psc_sh = ps;
        end else if (!e) begin
            m_per_sh = p; m_psc_sh = ps; m_done = 0;
        end else if (m_done == 0) begin
            if (m_psc >= m_psc_sh) begin
                m_psc = 0;
                stepNow = 1;
            end else begin
                m_psc = m_psc + 1;
            end
        end
        if (stepNow) begin
            m_tick = 1;
            if (m == 2'd1) begin
                if (m_count == 0) begin
                    m_count = p; m_unf = 1; updNow = 1;
                end else m_count = m_count - 1;
            end else if (m == 2'd2) begin
                if (m_up == 1) begin
                    if (m_count >= m_per_sh) begin
                        m_up = 0; m_ovf = 1;
                        m_count = (m_per_sh == 0) ? 0 : m_per_sh - 1;
                    end else m_count = (m_count + 1) & MASK;
                end else begin
                    if (m_count == 0) begin
                        m_up = 1; m_unf = 1; updNow = 1;
                        m_count = (m_per_sh == 0) ? 0 : 1;
                    end else m_count = m_count - 1;
                end
            end else begin
                if (m_count >= m_per_sh) begin
                    m_count = 0; m_ovf = 1; updNow = 1;
                end else m_count = (m_count + 1) & MASK;
            end
            if (updNow) begin
                m_per_sh = p; m_psc_sh = ps;
                if (os) m_done = 1;
            end
        end
        m_dir = (m == 2'd1) ? 0 : (m == 2'd2) ? m_up : 1;
        m_run = (e && m_done == 0) ? 1 : 0;
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit cr, input bit [1:0] m,
                                 input bit os, input int p, input int ps);
        logic [4:0] expFlags;
        rst = r; en = e; count_reset = cr; mode = m; one_shot = os;
        period = p[W-1:0]; prescale = ps[PW-1:0];
        @(posedge clk);
        modelUpdate(r, e, cr, m, os, p & MASK, ps & ((1 << PW) - 1));
        #1;
        expFlags = {m_dir[0], m_tick[0], m_ovf[0], m_unf[0], m_run[0]};
        checkOutput("model_count", {16'd0, count_val}, m_count);
        checkOutput("model_flags_dir_tick_ovf_unf_run", {27'd0, dir, tick, ovf, unf, running}, {27'd0, expFlags});
    endtask

    initial begin
        int expUp[5]      = '{1, 2, 3, 0, 1};
        int expUpOvf[5]   = '{0, 0, 0, 1, 0};
        int expCnt[9]     = '{1, 2, 3, 2, 1, 0, 1, 1, 2};
        int expCntDir[9]  = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        int expCntTick[9] = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
        int expOs[3]      = '{1, 2, 0};
        bit rr, rcr, re, ros;
        bit [1:0] rm;
        int rp, rps;
        int wOvfCnt, wTickCnt, wFirstOvf;

        w_rst = 1; w_en = 0; w_count_reset = 0; w_one_shot = 0; w_mode = 2'd0;
        w_period = 8'hFF; w_prescale = 4'hF;

        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0, 0, 3, 0);
        checkOutput("reset_count", {16'd0, count_val}, 0);
        checkOutput("reset_flags", {27'd0, dir, tick, ovf, unf, running}, 32'b10000);
        checkOutput("wide_reset_count", {24'd0, w_count_val}, 0);

        $display("[TB] up mode, period 3");
        applyStimulus(0, 0, 0, 0, 0, 3, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 3, 0);
            checkOutput("up_count", {16'd0, count_val}, expUp[i]);
            checkOutput("up_ovf", {31'd0, ovf}, expUpOvf[i]);
            checkOutput("up_tick", {31'd0, tick}, 1);
        end

        $display("[TB] down mode, prescale 2, period 4 then 6");
        applyStimulus(0, 1, 1, 1, 0, 4, 2);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 0, 4, 2);
        checkOutput("down_first_reload", {16'd0, count_val}, 4);
        checkOutput("down_first_unf", {31'd0, unf}, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 1, 0, 4, 2);
        checkOutput("down_mid", {16'd0, count_val}, 2);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 1, 0, 6, 2);
        checkOutput("down_bottom", {16'd0, count_val}, 0);
        checkOutput("down_bottom_no_unf", {31'd0, unf}, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 0, 6, 2);
        checkOutput("down_new_reload", {16'd0, count_val}, 6);
        checkOutput("down_new_unf", {31'd0, unf}, 1);

        $display("[TB] center mode, period 3");
        applyStimulus(0, 1, 1, 2, 0, 3, 0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 1, 0, 2, 0, 3, 1);
            checkOutput("center_count", {16'd0, count_val}, expCnt[i]);
            checkOutput("center_dir", {31'd0, dir}, expCntDir[i]);
            checkOutput("center_tick", {31'd0, tick}, expCntTick[i]);
            checkOutput("center_ovf", {31'd0, ovf}, (i == 3) ? 1 : 0);
            checkOutput("center_unf", {31'd0, unf}, (i == 6) ? 1 : 0);
        end

        $display("[TB] one-shot up, period 2");
        applyStimulus(0, 1, 1, 0, 1, 2, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 1, 2, 0);
            checkOutput("oneshot_count", {16'd0, count_val}, expOs[i]);
        end
        checkOutput("oneshot_ovf", {31'd0, ovf}, 1);
        checkOutput("oneshot_stopped", {31'd0, running}, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 1, 2, 0);
        checkOutput("oneshot_hold_count", {16'd0, count_val}, 0);
        checkOutput("oneshot_hold_tick", {31'd0, tick}, 0);
        applyStimulus(0, 0, 0, 0, 1, 2, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 1, 2, 0);
            checkOutput("oneshot_restart_count", {16'd0, count_val}, expOs[i]);
            checkOutput("oneshot_restart_running", {31'd0, running}, (i < 2) ? 1 : 0);
        end

        $display("[TB] count_reset on a wrap cycle");
        applyStimulus(0, 1, 1, 0, 0, 3, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 3, 0);
        checkOutput("pre_wrap_count", {16'd0, count_val}, 3);
        applyStimulus(0, 1, 1, 0, 0, 3, 0);
        checkOutput("cr_wrap_count", {16'd0, count_val}, 0);
        checkOutput("cr_wrap_ovf", {31'd0, ovf}, 0);
        checkOutput("cr_wrap_tick", {31'd0, tick}, 0);

        $display("[TB] rst mid-count");
        applyStimulus(0, 1, 1, 1, 0, 5, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 1, 0, 5, 0);
        checkOutput("pre_rst_count", {16'd0, count_val}, 4);
        applyStimulus(1, 1, 0, 1, 0, 5, 0);
        checkOutput("rst_mid_count", {16'd0, count_val}, 0);
        checkOutput("rst_mid_flags", {27'd0, dir, tick, ovf, unf, running}, 32'b10000);

        $display("[TB] period shrink below count while disabled");
        applyStimulus(0, 1, 1, 0, 0, 10, 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, 0, 0, 10, 0);
        applyStimulus(0, 0, 0, 0, 0, 5, 0);
        checkOutput("shrink_hold", {16'd0, count_val}, 9);
        applyStimulus(0, 1, 0, 0, 0, 5, 0);
        checkOutput("shrink_wrap_count", {16'd0, count_val}, 0);
        checkOutput("shrink_wrap_ovf", {31'd0, ovf}, 1);

        $display("[TB] randomized traffic");
        rm = 2'd0; rp = 5; rps = 1; ros = 0;
        for (int i = 0; i < 1500; i++) begin
            rr  = ($urandom_range(0, 149) == 0);
            rcr = ($urandom_range(0, 59) == 0);
            re  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) ros = ~ros;
            if ($urandom_range(0, 14) == 0)
                rp = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, MASK)) : int'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) rps = $urandom_range(0, 3);
            applyStimulus(rr, re, rcr, rm, ros, rp, rps);
        end

        $display("[TB] WIDTH=8 PSC_WIDTH=4 long wrap");
        rst = 1;
        w_rst = 0; w_en = 0;
        @(posedge clk); #1;
        checkOutput("wide_idle_count", {24'd0, w_count_val}, 0);
        w_en = 1;
        wOvfCnt = 0; wTickCnt = 0; wFirstOvf = -1;
        for (int c = 1; c <= 8192; c++) begin
            @(posedge clk); #1;
            if (w_ovf) begin
                wOvfCnt++;
                if (wFirstOvf < 0) wFirstOvf = c;
            end
            if (w_tick) wTickCnt++;
        end
        checkOutput("wide_ovf_count", wOvfCnt, 2);
        checkOutput("wide_tick_count", wTickCnt, 512);
        checkOutput("wide_first_ovf_cycle", wFirstOvf, 4096);
        checkOutput("wide_final_count", {24'd0, w_count_val}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_timebase.md
# pwm_timebase

Parametrised timebase counter for the PWM generator, successor to the fixed 16-bit up/down counter. It adds configurable counter and prescaler widths, a center-aligned (up-down) mode, and one-shot operation. Period and prescale are shadow-buffered so register writes take effect only at an update event. It drives the compare/output stage and the interrupt/status logic with single-cycle event pulses.

## Interface
Parameters:
- WIDTH, 16, counter and period width (2..32)
- PSC_WIDTH, 8, prescaler width (1..16)

Ports:
- clk  in  1  peripheral clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; low freezes count, prescaler and direction
- count_reset  in  1  synchronous software clear
- mode  in  2  00 up, 01 down, 10 center-aligned, 11 treated as up
- one_shot  in  1  stop after the first update event
- period  in  WIDTH  top value, shadow-buffered
- prescale  in  PSC_WIDTH  divide ratio minus one, shadow-buffered
- count_val  out  WIDTH  current count
- dir  out  1  1 = counting up, 0 = counting down
- tick  out  1  one-cycle pulse on every counting step
- ovf  out  1  one-cycle pulse on reaching or turning at the top
- unf  out  1  one-cycle pulse on reaching or turning at the bottom
- running  out  1  counter actively counting

## Operation
- Priority: rst > count_reset > en.
- **rst:**
  - count_val=0, prescaler count=0, period_sh=0, prescale_sh=0.
  - Internal direction=up; tick/ovf/unf=0; done=0.
- **count_reset:**
  - Same as rst for count, prescaler, direction, done and pulses.
  - Shadows load the current period/prescale inputs.
- **en=0:**
  - count, prescaler and direction hold; pulses are 0.
  - Shadows load the inputs every cycle, so the first enabled cycle uses current values.
  - done clears.
- **running** = en & !done.
- **Prescaler** (only while running):
  - Counts 0..prescale_sh.
  - A step occurs in the cycle it equals prescale_sh; the prescaler then returns to 0.
  - prescale_sh=0 gives a step every cycle.
- **Up mode, on step:**
  - If count >= period_sh: count←0, ovf, update event.
  - Otherwise count+1.
- **Down mode, on step:**
  - If count==0: count←period input (new shadow value), unf, update event.
  - Otherwise count−1.
- **Center mode, on step:**
  - Going up, count >= period_sh: direction←down, count←period_sh−1 (0 if period_sh==0), ovf.
  - Going up, otherwise: count+1.
  - Going down, count==0: direction←up, count←1 (0 if period_sh==0), unf, update event.
  - Going down, otherwise: count−1.
  - Full cycle length is 2·period_sh steps.
- **Update event:** period_sh and prescale_sh load from the inputs in the same edge.
- **one_shot=1:**
  - An update event sets done; the count holds at the value just loaded.
  - Restart requires count_reset or an en low pulse.
- **dir output:** 1 in up mode, 0 in down mode, internal direction in center mode.
- **Mode change while running:**
  - Takes effect on the next step; the count is not altered.
  - Entering center mode keeps the last internal direction.
- Arithmetic is modulo 2^WIDTH. The >= comparison recovers from count above period after a shrink.

## Timing
- All outputs are registered.
- tick, ovf and unf are high in exactly the cycle count_val shows the post-step value. ovf/unf coincide with tick.
- Step spacing is prescale_sh+1 enabled cycles.
- First step occurs prescale_sh+1 cycles after en rises from a cleared prescaler.
- Writes to period/prescale while running are invisible until the next update event.
- rst or count_reset asserted mid-count takes effect at the next edge. Outputs read reset values in the following cycle.
- Simultaneous count_reset and step: count_reset wins, and no pulse is produced.
- en dropping on a step cycle: no step, no pulse; the prescaler holds at prescale_sh.

## Test plan
- **Up, prescale 0, period 3:**
  - count 0,1,2,3,0 each cycle; ovf only on the cycle count returns to 0.
  - tick every cycle.
- **Down, prescale 2, period 4:**
  - count changes every 3 cycles: 4,3,2,1,0,4.
  - unf on the 0→4 step.
  - Change period to 6 mid-run: reload is 6 only at the next wrap.
- **Center, period 3:**
  - Sequence 0,1,2,3,2,1,0,1.
  - ovf at 3→2, unf at 0→1; dir flips at those steps.
  - New prescale is applied only after unf.
- **One-shot up, period 2:**
  - 0,1,2,0 then count stays 0, running=0.
  - en low one cycle then high restarts: 1,2,0.
- **Priority/boundary cases:**
  - count_reset on the same cycle as a wrap: count=0, no ovf.
  - rst mid-count: all outputs 0 next cycle, dir=1.
  - Up mode with count 9 and period reduced to 5 while en=0: first step wraps to 0 with ovf.
- **WIDTH=8, PSC_WIDTH=4, period 255, prescale 15:**
  - Full 256-step wrap every 4096 cycles; ovf count matches.
